data_mem_ctrl: RTL and testbench

Responder side of the datapath's memory-request signals (MemRead, MemWrite). It accepts one load/store per instruction from the single-cycle datapath and performs the access on a word-wide synchronous SRAM with a fixed number of wait states. It holds the pipeline with `stall` until the access completes, then returns load data in `rdata`. It sits between the control/datapath outputs and the external data memory.

---
 rtl/data_mem_ctrl.sv | 128 ++++++++++++
 tb/tb_data_mem_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: responder for the datapath's MemRead/MemWrite requests.
// Performs one word access per instruction on a synchronous SRAM with a fixed
// number of wait states, holding the pipeline with stall until it completes.
module data_mem_ctrl #(
  parameter int unsigned WAIT_CYCLES = 2,
  parameter int unsigned ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              stall,
  output logic              err,
  output logic              sram_ce,
  output logic              sram_we,
  output logic [ADDR_W-3:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata
);

  typedef enum logic [1:0] {StIdle, StAccess, StDone} state_e;

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  state_e            r_state;
  state_e            w_state_next;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_next;
  logic [ADDR_W-3:0] r_addr;
  logic [31:0]       r_wdata;
  logic [31:0]       r_rdata;
  logic              r_is_write;
  logic              r_err;

  logic              w_req;
  logic              w_misaligned;
  logic              w_accept;
  logic              w_reject;
  logic              w_capture;

  // Request decode; only meaningful in IDLE (DONE-cycle requests belong to
  // the instruction that just finished).
  always_comb begin
    w_req        = MemRead | MemWrite;
    w_misaligned = (addr[1:0] != 2'b00);
    w_accept     = (r_state == StIdle) && w_req && !w_misaligned;
    w_reject     = (r_state == StIdle) && w_req && (w_misaligned || (MemRead && MemWrite));
  end

  // Next-state, counter and combinational outputs.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_capture    = 1'b0;
    stall        = 1'b0;
    sram_ce      = 1'b0;
    sram_we      = 1'b0;
    case (r_state)
      StIdle: begin
        if (w_accept) begin
          // Stall in the accepting cycle so the PC holds this edge.
          stall        = 1'b1;
          w_cnt_next   = WaitInit;
          w_state_next = StAccess;
        end
      end
      StAccess: begin
        stall   = 1'b1;
        sram_ce = 1'b1;
        sram_we = r_is_write;
        if (r_cnt == 4'd0) begin
          w_capture    = !r_is_write;
          w_state_next = StDone;
        end else begin
          w_cnt_next = r_cnt - 4'd1;
        end
      end
      StDone: begin
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase
  end

  // State register, wait counter and error pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= StIdle;
      r_cnt   <= 4'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_err   <= w_reject;
    end
  end

  // Request latches and load-data capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_addr     <= '0;
      r_wdata    <= 32'd0;
      r_is_write <= 1'b0;
      r_rdata    <= 32'd0;
    end else begin
      if (w_accept) begin
        r_addr     <= addr[ADDR_W-1:2];
        r_wdata    <= wdata;
        // MemWrite wins when both are asserted.
        r_is_write <= MemWrite;
      end
      if (w_capture) begin
        r_rdata <= sram_rdata;
      end
    end
  end

  assign rdata      = r_rdata;
  assign err        = r_err;
  assign sram_addr  = r_addr;
  assign sram_wdata = r_wdata;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: randomized self-checking bench for data_mem_ctrl.
// Two instances (WAIT_CYCLES=2 and WAIT_CYCLES=0) share the stimulus bus;
// sel steers requests to one of them and picks which outputs are observed.
module tb_data_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sel;
  logic        rd;
  logic        wr;
  logic [31:0] addr;
  logic [31:0] wdata;

  logic        mr0, mw0, mr1, mw1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1, err0, err1, ce0, ce1, we0, we1;
  logic [29:0] sa0, sa1;
  logic [31:0] swd0, swd1, srd0, srd1;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  logic [31:0] ref_rd  [2];

  int n_checks;
  int n_fail;

  assign mr0 = rd & !sel;
  assign mw0 = wr & !sel;
  assign mr1 = rd & sel;
  assign mw1 = wr & sel;

  data_mem_ctrl #(.WAIT_CYCLES(2), .ADDR_W(32)) u_dut0 (
    .clk        (clk),
    .reset      (rst_n),
    .MemRead    (mr0),
    .MemWrite   (mw0),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata0),
    .stall      (stall0),
    .err        (err0),
    .sram_ce    (ce0),
    .sram_we    (we0),
    .sram_addr  (sa0),
    .sram_wdata (swd0),
    .sram_rdata (srd0)
  );

  data_mem_ctrl #(.WAIT_CYCLES(0), .ADDR_W(32)) u_dut1 (
    .clk        (clk),
    .reset      (rst_n),
    .MemRead    (mr1),
    .MemWrite   (mw1),
    .addr       (addr),
    .wdata      (wdata),
    .rdata      (rdata1),
    .stall      (stall1),
    .err        (err1),
    .sram_ce    (ce1),
    .sram_we    (we1),
    .sram_addr  (sa1),
    .sram_wdata (swd1),
    .sram_rdata (srd1)
  );

  // SRAM model: read data follows the word address, writes land on the edge.
  assign srd0 = mem[sa0[7:0]];
  assign srd1 = mem[sa1[7:0]];

  always @(posedge clk) begin
    if (ce0 && we0) mem[sa0[7:0]] <= swd0;
    if (ce1 && we1) mem[sa1[7:0]] <= swd1;
  end

  // Observed outputs of the selected instance.
  logic [31:0] ob_rdata, ob_swd;
  logic [29:0] ob_sa;
  logic        ob_stall, ob_err, ob_ce, ob_we;
  assign ob_rdata = sel ? rdata1 : rdata0;
  assign ob_swd   = sel ? swd1   : swd0;
  assign ob_sa    = sel ? sa1    : sa0;
  assign ob_stall = sel ? stall1 : stall0;
  assign ob_err   = sel ? err1   : err0;
  assign ob_ce    = sel ? ce1    : ce0;
  assign ob_we    = sel ? we1    : we0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      rd = 1'b0;
      wr = 1'b0;
    end
  endtask

  // One instruction's memory request, checked cycle by cycle from the
  // request cycle (c=0) to DONE (valid) or the err cycle (rejected/none).
  task automatic do_access(input bit s, input bit rd_i, input bit wr_i,
                           input logic [31:0] a, input logic [31:0] d, input bit hold);
    int          w;
    int          last;
    bit          mis, valid, errx, stall_x, ce_x;
    logic [31:0] old_rd, new_rd;
    w      = s ? 0 : 2;
    mis    = (a[1:0] != 2'b00);
    valid  = (rd_i || wr_i) && !mis;
    errx   = (rd_i || wr_i) && (mis || (rd_i && wr_i));
    old_rd = ref_rd[s];
    new_rd = old_rd;
    if (valid) begin
      if (wr_i) ref_mem[a[9:2]] = d;
      else      new_rd = ref_mem[a[9:2]];
    end
    last = valid ? w + 2 : 1;

    @(posedge clk);
    #1;
    sel   = s;
    rd    = rd_i;
    wr    = wr_i;
    addr  = a;
    wdata = d;
    for (int c = 0; c <= last; c++) begin
      if (c > 0) begin
        @(posedge clk);
        #1;
        if (c == 1 && (!hold || !valid)) begin
          rd    = 1'b0;
          wr    = 1'b0;
          addr  = $urandom;
          wdata = $urandom;
        end
      end
      @(negedge clk);
      stall_x = valid && (c <= w + 1);
      ce_x    = valid && (c >= 1) && (c <= w + 1);
      check("stall", 32'(ob_stall), 32'(stall_x));
      check("sram_ce", 32'(ob_ce), 32'(ce_x));
      check("err", 32'(ob_err), 32'((c == 1) && errx));
      check("rdata", ob_rdata, (valid && c == last) ? new_rd : old_rd);
      if (ce_x) begin
        check("sram_we", 32'(ob_we), 32'(wr_i));
        check("sram_addr", 32'(ob_sa), 32'(a[31:2]));
        if (wr_i) check("sram_wdata", ob_swd, d);
      end
    end
    ref_rd[s] = new_rd;
  endtask

  initial begin
    logic [31:0] v;
    n_checks = 0;
    n_fail   = 0;
    rst_n    = 1'b0;
    sel      = 1'b0;
    rd       = 1'b0;
    wr       = 1'b0;
    addr     = 32'd0;
    wdata    = 32'd0;
    for (int i = 0; i < 256; i++) begin
      v          = $urandom;
      mem[i]     = v;
      ref_mem[i] = v;
    end
    mem[8'h10]     = 32'hDEADBEEF;
    ref_mem[8'h10] = 32'hDEADBEEF;
    ref_rd[0]      = 32'd0;
    ref_rd[1]      = 32'd0;

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_stall", 32'(stall0), 32'd0);
    check("rst_err", 32'(err0), 32'd0);
    check("rst_ce", 32'(ce0), 32'd0);
    check("rst_we", 32'(we0), 32'd0);
    check("rst_sram_addr", 32'(sa0), 32'd0);
    check("rst_sram_wdata", swd0, 32'd0);
    check("rst_rdata0", rdata0, 32'd0);
    check("rst_rdata1", rdata1, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Directed cases.
    do_access(1'b0, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    do_access(1'b0, 1'b0, 1'b1, 32'h44, 32'h12345678, 1'b1);
    do_access(1'b0, 1'b1, 1'b0, 32'h44, 32'h0, 1'b0);
    do_access(1'b0, 1'b1, 1'b0, 32'h42, 32'h0, 1'b0);
    do_access(1'b0, 1'b1, 1'b1, 32'h48, 32'hA5A5A5A5, 1'b0);
    do_access(1'b0, 1'b1, 1'b0, 32'h48, 32'h0, 1'b1);
    idle(1);

    // Reset in the second ACCESS cycle of a load.
    @(posedge clk);
    #1;
    sel  = 1'b0;
    rd   = 1'b1;
    addr = 32'h40;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    rd    = 1'b0;
    @(negedge clk);
    check("mid_ce_before", 32'(ce0), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_stall", 32'(stall0), 32'd0);
    check("mid_ce", 32'(ce0), 32'd0);
    check("mid_rdata0", rdata0, 32'd0);
    check("mid_rdata1", rdata1, 32'd0);
    check("mid_sram_addr", 32'(sa0), 32'd0);
    ref_rd[0] = 32'd0;
    ref_rd[1] = 32'd0;
    idle(2);

    // Zero-wait-state instance.
    do_access(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0);
    do_access(1'b1, 1'b0, 1'b1, 32'h80, 32'hCAFEF00D, 1'b1);
    do_access(1'b1, 1'b1, 1'b0, 32'h80, 32'h0, 1'b0);

    // Randomized mix across both instances.
    for (int i = 0; i < 80; i++) begin
      int          op;
      bit          s, h;
      logic [31:0] a;
      s  = 1'($urandom_range(0, 1));
      h  = 1'($urandom_range(0, 1));
      op = $urandom_range(0, 9);
      a  = {22'd0, 8'($urandom), 2'b00};
      case (op)
        0, 1, 2, 3: do_access(s, 1'b1, 1'b0, a, $urandom, h);
        4, 5, 6:    do_access(s, 1'b0, 1'b1, a, $urandom, h);
        7:          do_access(s, 1'b1, 1'b1, a, $urandom, h);
        8:          do_access(s, 1'b0, 1'b0, a, $urandom, h);
        default:    do_access(s, 1'b1, 1'($urandom_range(0, 1)),
                              a | 32'($urandom_range(1, 3)), $urandom, h);
      endcase
    end
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
